// File: rtl/ob_pkg.sv
// Order-book shared types.
// Command bundle used by the conditional table and issue path.
package ob_pkg;

  typedef struct packed {
    logic [7:0]  uid;
    logic        is_lmt;
    logic        side;
    logic [15:0] qty;
    logic [31:0] px;
  } cmd_t;

endpackage

// File: rtl/ob_cn_table_issue.sv
// Conditional-table issue stage.
// Round-robin picks matured entries into one registered output slot.
module ob_cn_table_issue
  import ob_pkg::*;
#(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       mtr_vld_r,
  input  cmd_t [N-1:0]       mtr_cmd_r,
  input  logic [N-1:0]       cancel_hit,
  output logic [N-1:0]       dl_vld,
  output logic               out_vld_r,
  output cmd_t               out_cmd_r,
  input  logic               out_accept,
  output logic               busy_r,
  output logic [31:0]        issue_cnt_r
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr_r;
  logic [N-1:0]  mask_r;
  logic [N-1:0]  elig;
  logic [PW-1:0] sel;
  logic [PW-1:0] idx;
  logic          found;
  logic          slot_free;
  logic          load;

  // Just-issued entry is masked for one cycle so a slow dealloc can't re-issue it.
  assign elig      = mtr_vld_r & ~cancel_hit & ~mask_r;
  assign slot_free = !out_vld_r || out_accept;
  assign load      = !rst && slot_free && found;
  assign busy_r    = (|mtr_vld_r) || out_vld_r;

  // First eligible entry at or above ptr_r, wrapping through N-1 to 0.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr_r + PW'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // One-hot dealloc pulse to the entry being loaded this cycle.
  always_comb begin
    dl_vld = '0;
    if (load) begin
      dl_vld = N'(1) << sel;
    end
  end

  // Output slot, RR pointer and one-cycle re-select mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_r <= 1'b0;
      out_cmd_r <= '0;
      ptr_r     <= '0;
      mask_r    <= '0;
    end else begin
      mask_r <= dl_vld;
      if (load) begin
        out_vld_r <= 1'b1;
        out_cmd_r <= mtr_cmd_r[sel];
        ptr_r     <= sel + 1'b1;
      end else if (out_accept) begin
        out_vld_r <= 1'b0;
      end
    end
  end

  // Saturating count of downstream handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_r <= '0;
    end else if (out_vld_r && out_accept && issue_cnt_r != 32'hFFFF_FFFF) begin
      issue_cnt_r <= issue_cnt_r + 32'd1;
    end
  end

endmodule

// File: tb/tb_ob_cn_table_issue.sv
// Bench for ob_cn_table_issue.
// Scoreboard queue of issued commands plus a cycle-level RR model.
module tb_ob_cn_table_issue;
  import ob_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] mtr_vld_r;
  cmd_t [N-1:0] mtr_cmd_r;
  logic [N-1:0] cancel_hit;
  logic [N-1:0] dl_vld;
  logic         out_vld_r;
  cmd_t         out_cmd_r;
  logic         out_accept;
  logic         busy_r;
  logic [31:0]  issue_cnt_r;

  ob_cn_table_issue #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .mtr_vld_r(mtr_vld_r),
    .mtr_cmd_r(mtr_cmd_r),
    .cancel_hit(cancel_hit),
    .dl_vld(dl_vld),
    .out_vld_r(out_vld_r),
    .out_cmd_r(out_cmd_r),
    .out_accept(out_accept),
    .busy_r(busy_r),
    .issue_cnt_r(issue_cnt_r)
  );

  always #5 clk = ~clk;

  int n_run;
  int n_fail;
  cmd_t exp_q[$];
  int issued[$];
  int m_ptr;
  logic m_ovld;
  logic [N-1:0] m_mask;
  logic [31:0] m_cnt;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic new_cmds();
    for (int i = 0; i < N; i++) begin
      mtr_cmd_r[i].uid    = 8'($urandom);
      mtr_cmd_r[i].is_lmt = 1'($urandom);
      mtr_cmd_r[i].side   = 1'($urandom);
      mtr_cmd_r[i].qty    = 16'($urandom);
      mtr_cmd_r[i].px     = $urandom;
    end
  endtask

  task automatic model_clear();
    m_ptr  = 0;
    m_ovld = 1'b0;
    m_mask = '0;
    m_cnt  = '0;
    exp_q.delete();
    issued.delete();
  endtask

  // Called at a negedge with inputs set; ends at the next negedge.
  task automatic cycle();
    int sel;
    int j;
    logic ld;
    logic [N-1:0] elig;
    logic [N-1:0] dexp;
    cmd_t e;
    #1;
    elig = mtr_vld_r & ~cancel_hit & ~m_mask;
    sel = -1;
    for (int i = 0; i < N; i++) begin
      j = (m_ptr + i) % N;
      if (sel < 0 && elig[j]) sel = j;
    end
    ld = (!m_ovld || out_accept) && sel >= 0;
    dexp = ld ? N'(1 << sel) : '0;
    check("dl_vld", 64'(dl_vld), 64'(dexp));
    if (m_ovld && out_accept) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("accept_cmd", 64'(out_cmd_r), 64'(e));
      end
      if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
    end
    if (ld) begin
      exp_q.push_back(mtr_cmd_r[sel]);
      issued.push_back(sel);
      m_ptr = (sel + 1) % N;
      m_ovld = 1'b1;
    end else if (out_accept) begin
      m_ovld = 1'b0;
    end
    m_mask = dexp;
    @(posedge clk);
    @(negedge clk);
    mtr_vld_r = mtr_vld_r & ~dexp & ~cancel_hit;
    check("out_vld", 64'(out_vld_r), 64'(m_ovld));
    check("cnt", 64'(issue_cnt_r), 64'(m_cnt));
    check("busy", 64'(busy_r), 64'((|mtr_vld_r) || m_ovld));
    if (m_ovld && exp_q.size() > 0)
      check("out_cmd", 64'(out_cmd_r), 64'(exp_q[0]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    out_accept = 1'b0;
    cancel_hit = '0;
    #1;
    check("rst_dl", 64'(dl_vld), 64'(0));
    @(posedge clk);
    @(negedge clk);
    mtr_vld_r = '0;
    #1;
    check("rst_vld", 64'(out_vld_r), 64'(0));
    check("rst_cmd", 64'(out_cmd_r), 64'(0));
    check("rst_cnt", 64'(issue_cnt_r), 64'(0));
    check("rst_busy", 64'(busy_r), 64'(0));
    check("rst_ptr", 64'(dut.ptr_r), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    int exp_rr[5];
    n_run = 0;
    n_fail = 0;
    rst = 1'b1;
    mtr_vld_r = '0;
    cancel_hit = '0;
    out_accept = 1'b0;
    new_cmds();
    @(negedge clk);
    do_reset();

    // single issue
    mtr_vld_r = 4'b0100;
    out_accept = 1'b1;
    cycle();
    check("single_sel", 64'(issued[0]), 64'(2));
    cycle();
    check("single_cnt", 64'(issue_cnt_r), 64'(1));

    // round robin, all entries kept valid
    do_reset();
    new_cmds();
    out_accept = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mtr_vld_r = 4'b1111;
      cycle();
    end
    exp_rr = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++)
      check("rr_order", 64'(issued[k]), 64'(exp_rr[k]));
    mtr_vld_r = '0;
    cycle();

    // backpressure
    do_reset();
    new_cmds();
    mtr_vld_r = 4'b0011;
    out_accept = 1'b1;
    cycle();
    out_accept = 1'b0;
    for (int k = 0; k < 5; k++) cycle();
    check("bp_held", 64'(issued.size()), 64'(1));
    out_accept = 1'b1;
    cycle();
    check("bp_next", 64'(issued[1]), 64'(1));
    cycle();

    // cancel race
    do_reset();
    new_cmds();
    mtr_vld_r = 4'b0011;
    cancel_hit = 4'b0001;
    out_accept = 1'b1;
    cycle();
    cancel_hit = '0;
    check("cancel_sel", 64'(issued[0]), 64'(1));
    for (int k = 0; k < 4; k++) cycle();
    check("cancel_cnt", 64'(issued.size()), 64'(1));

    // wrap from ptr 3
    do_reset();
    new_cmds();
    mtr_vld_r = 4'b0100;
    out_accept = 1'b1;
    cycle();
    cycle();
    check("wrap_ptr3", 64'(dut.ptr_r), 64'(3));
    mtr_vld_r = 4'b0010;
    cycle();
    check("wrap_sel", 64'(issued[1]), 64'(1));
    check("wrap_ptr", 64'(dut.ptr_r), 64'(2));
    cycle();

    // saturation, then reset mid-hold
    do_reset();
    new_cmds();
    force dut.issue_cnt_r = 32'hFFFF_FFFE;
    #1;
    release dut.issue_cnt_r;
    m_cnt = 32'hFFFF_FFFE;
    out_accept = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mtr_vld_r = 4'b1111;
      cycle();
    end
    check("sat_cnt", 64'(issue_cnt_r), 64'hFFFF_FFFF);
    out_accept = 1'b0;
    mtr_vld_r = 4'b1111;
    cycle();
    check("hold_vld", 64'(out_vld_r), 64'(1));
    mtr_vld_r = 4'b1111;
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ob_cn_table_issue.md
OB_CN_TABLE_ISSUE -- requirements
Module: ob_cn_table_issue

Interface
REQ-001 Parameter N, default 4, number of conditional-table entries scanned; N SHALL be >= 2 and a power of two.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 mtr_vld_r  input  N  per-entry "entry has matured" flag, registered in each entry.
REQ-005 mtr_cmd_r  input  N x ob_pkg::cmd_t  per-entry command; the opcode has already been converted to Market/Limit.
REQ-006 cancel_hit  input  N  per-entry cancel hit this cycle.
REQ-007 dl_vld  output  N  one-hot deallocation pulse back to the issued entry.
REQ-008 out_vld_r  output  1  registered issue-valid to the order-book command path.
REQ-009 out_cmd_r  output  ob_pkg::cmd_t  registered issued command.
REQ-010 out_accept  input  1  downstream accepts out_cmd_r this cycle when out_vld_r=1.
REQ-011 busy_r  output  1  1 when any mtr_vld_r bit is set or out_vld_r=1.
REQ-012 issue_cnt_r  output  32  count of commands accepted downstream.

Function
REQ-013 Eligible vector elig = mtr_vld_r & ~cancel_hit; a cancelled entry SHALL never be selected in the cycle of its cancel.
REQ-014 Output slot free when (out_vld_r=0) or (out_vld_r=1 and out_accept=1).
REQ-015 Selection is round-robin: sel = the first set bit of elig, searching upward from ptr_r (inclusive) and wrapping from N-1 to 0.
REQ-016 Load occurs when the slot is free and elig != 0: out_cmd_r <= mtr_cmd_r[sel], out_vld_r <= 1, ptr_r <= (sel+1) mod N.
REQ-017 dl_vld[sel] SHALL pulse for exactly one cycle, combinationally in the load cycle; all other dl_vld bits are 0; dl_vld=0 when no load occurs.
REQ-018 Latency: an entry whose mtr_vld_r rises at cycle t, with the slot free and the entry first in RR order, SHALL appear on out_vld_r at t+1.
REQ-019 Hold: while out_vld_r=1 and out_accept=0, out_cmd_r and ptr_r SHALL be stable and dl_vld=0.
REQ-020 Back-to-back: accept and load in the same cycle SHALL give continuous out_vld_r=1 with the new command, sustaining 1 issue/cycle.
REQ-021 Accept with no eligible entry: out_vld_r <= 0 next cycle.
REQ-022 out_accept while out_vld_r=0 SHALL be ignored and SHALL NOT change issue_cnt_r.
REQ-023 issue_cnt_r increments by 1 on each out_vld_r & out_accept and saturates at 32'hFFFF_FFFF; it does not wrap.
REQ-024 Once a command is loaded into out_cmd_r, a later cancel of the same UID SHALL NOT retract it; out_vld_r stays 1 until accepted.
REQ-025 An entry whose mtr_vld_r is still 1 in the cycle after its dl_vld pulse SHALL NOT be re-selected in that cycle (mask the last-issued index for one cycle).
REQ-026 ptr_r width is log2(N); wrap from N-1 to 0 is mandatory.

Reset
REQ-027 While rst=1: out_vld_r=0, out_cmd_r='0, ptr_r=0, issue_cnt_r=0, dl_vld=0, the re-select mask cleared.
REQ-028 Reset asserted mid-hold SHALL drop out_vld_r the following cycle with no dl_vld pulse and no count increment.
REQ-029 busy_r is 0 out of reset until an input mtr_vld_r bit is observed.

Verification
REQ-030 Single issue: mtr_vld_r=4'b0100 with out_accept=1 -> dl_vld=4'b0100 in the same cycle; out_vld_r=1 with cmd[2] the next cycle; issue_cnt_r=1 after accept.
REQ-031 Round-robin: mtr_vld_r=4'b1111 held with out_accept=1 -> issue order 0,1,2,3,0; one issue per cycle, no gaps.
REQ-032 Backpressure: out_accept=0 for 5 cycles with out_vld_r=1 -> out_cmd_r stable and dl_vld=0 for 5 cycles; the next entry loads in the accept cycle.
REQ-033 Cancel race: mtr_vld_r=4'b0011, ptr_r=0, cancel_hit=4'b0001 -> entry 1 selected, no dl_vld[0]; entry 0 is never issued afterwards.
REQ-034 Wrap: ptr_r=3, mtr_vld_r=4'b0010 -> sel=1, ptr_r becomes 2.
REQ-035 Saturation/reset: force issue_cnt_r=32'hFFFF_FFFE, then accept 3 commands -> 32'hFFFF_FFFF; rst=1 -> all outputs 0 the next cycle.
